// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for clk_freq_meter: FSM state encoding and default
// parameter values. Optional feature macro: CLK_FREQ_METER_SYNC_EN.
package clk_freq_meter_pkg;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned EXP_PERIOD_DEF = 20;
  localparam int unsigned TOL_DEF        = 1;
  localparam int unsigned LOCK_CNT_DEF   = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2
  } fm_state_t;

endpackage

// File: rtl/clk_freq_meter_edge_sync.sv
// edge_sync: optional 2-flop synchronizer, sample register and rise detector.
// Define CLK_FREQ_METER_SYNC_EN for an asynchronous source (adds 2 cycles).
module edge_sync
  import clk_freq_meter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic w_in;
  logic r_samp;
  logic r_prev;

`ifdef CLK_FREQ_METER_SYNC_EN
  logic r_meta;
  logic r_sync;

  // Two-stage synchronizer for an input from another clock domain
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign w_in = r_sync;
`else
  assign w_in = i_d;
`endif

  // Sample register plus one-cycle history for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_samp <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_samp <= w_in;
      r_prev <= r_samp;
    end
  end

  assign o_rise = r_samp & ~r_prev;

endmodule

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: measures the rise-to-rise period of freq_in in clk cycles,
// tracks lock against EXP_PERIOD +/- TOL and flags loss of input.
// Optional macro CLK_FREQ_METER_SYNC_EN inserts an input synchronizer.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int unsigned TOL        = TOL_DEF,
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freq_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W:0]    EXP_V   = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_V   = (CNT_W+1)'(TOL);
  localparam logic [GOOD_W-1:0] LOCK_V  = GOOD_W'(LOCK_CNT);

  fm_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good;
  logic [CNT_W-1:0]  r_period;
  logic              r_pv;
  logic              r_locked;
  logic              r_lost;

  logic              w_rise;
  logic [CNT_W:0]    w_cnt_x;
  logic [CNT_W:0]    w_diff;
  logic              w_in_tol;
  logic [GOOD_W-1:0] w_good_next;

  edge_sync u_edge_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (freq_in),
    .o_rise  (w_rise)
  );

  // Absolute deviation of the running count (the period about to be
  // reported) from the expected period, one bit wider so nothing wraps
  always_comb begin
    w_cnt_x     = {1'b0, r_cnt};
    w_diff      = (w_cnt_x >= EXP_V) ? (w_cnt_x - EXP_V) : (EXP_V - w_cnt_x);
    w_in_tol    = (w_diff <= TOL_V);
    w_good_next = (r_good == LOCK_V) ? r_good : (r_good + GOOD_W'(1));
  end

  // Measurement FSM, period counter, lock qualification and loss timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= SEARCH;
      r_cnt    <= '0;
      r_good   <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_rise) begin
            r_state <= MEASURE;
            r_cnt   <= CNT_W'(1);
            r_lost  <= 1'b0;
          end
        end
        MEASURE, TRACK: begin
          // A rise takes priority over the saturation timeout
          if (w_rise) begin
            r_period <= r_cnt;
            r_pv     <= 1'b1;
            r_cnt    <= CNT_W'(1);
            r_state  <= TRACK;
            if (w_in_tol) begin
              r_good <= w_good_next;
              if (w_good_next == LOCK_V) begin
                r_locked <= 1'b1;
              end
            end else begin
              r_good   <= '0;
              r_locked <= 1'b0;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_lost   <= 1'b1;
            r_locked <= 1'b0;
            r_good   <= '0;
            r_state  <= SEARCH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign period       = r_period;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign lost         = r_lost;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter. The reference model works on
// timestamps of detected rises rather than on a counter.
module tb_clk_freq_meter;

  localparam int CNT_W = 8;
  localparam int EXP   = 20;
  localparam int TOL   = 1;
  localparam int LOCKN = 4;
  localparam int MAXC  = 255;
`ifdef CLK_FREQ_METER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int HSIZE = 65536;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             freq_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;

  always #5 clk = ~clk;

  clk_freq_meter #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .LOCK_CNT   (LOCKN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freq_in      (freq_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dut_pv_cnt = 0;
  bit hv [HSIZE];
  bit rv [HSIZE];

  // model state: timestamp of last rise, whether a first rise has been seen
  bit m_active, m_pv, m_locked, m_lost;
  int m_period, m_last, m_good, m_rst_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // pin value driven in cycle k, as seen after the most recent reset
  function automatic bit vv(input int k);
    if (k < 0 || k < m_rst_edge) return 1'b0;
    return hv[k];
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // expected outputs after clock edge e
  task automatic model_step(input int e);
    bit rise;
    int p;
    if (rv[e-1] == 1'b0) begin
      m_active = 0; m_pv = 0; m_locked = 0; m_lost = 0;
      m_period = 0; m_good = 0; m_rst_edge = e;
      return;
    end
    m_pv = 0;
    rise = vv(e - LAT) && !vv(e - LAT - 1);
    if (rise) begin
      if (!m_active) begin
        m_active = 1; m_last = e; m_lost = 0;
      end else begin
        p = e - m_last;
        m_period = p; m_pv = 1; m_last = e;
        if (absdiff(p, EXP) <= TOL) begin
          if (m_good < LOCKN) m_good++;
          if (m_good == LOCKN) m_locked = 1;
        end else begin
          m_good = 0; m_locked = 0;
        end
      end
    end else if (m_active && (e - m_last) == MAXC) begin
      m_lost = 1; m_locked = 0; m_good = 0; m_active = 0;
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cyc >= 1) begin
      model_step(cyc);
      chk("period",       32'(period),       32'(m_period));
      chk("period_valid", 32'(period_valid), 32'(m_pv));
      chk("locked",       32'(locked),       32'(m_locked));
      chk("lost",         32'(lost),         32'(m_lost));
      if (period_valid === 1'b1) dut_pv_cnt++;
    end
  end

  task automatic tick(input bit fin, input bit rn);
    @(posedge clk);
    #1;
    if (cyc < HSIZE - 1) cyc++;
    freq_in = fin;
    rst_n   = rn;
    hv[cyc] = fin;
    rv[cyc] = rn;
  endtask

  task automatic pulse(input int p);
    for (int i = 0; i < p; i++) tick(i < p / 2, 1'b1);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) tick(v, 1'b1);
  endtask

  int n0;
  int sel;
  int p;

  initial begin
    rst_n = 1'b0; freq_in = 1'b0;
    hv[0] = 1'b0; rv[0] = 1'b0;
    m_active = 0; m_pv = 0; m_locked = 0; m_lost = 0;
    m_period = 0; m_good = 0; m_last = 0; m_rst_edge = 0;

    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_lost",   32'(lost),   32'd0);
    hold(1'b0, 2);

    // nominal input: lock on the 4th reported period
    n0 = dut_pv_cnt;
    repeat (4) pulse(20);
    chk("A_pv_count3", 32'(dut_pv_cnt - n0), 32'd3);
    chk("A_not_locked", 32'(locked), 32'd0);
    pulse(20);
    chk("A_locked", 32'(locked), 32'd1);
    chk("A_period", 32'(period), 32'd20);
    chk("A_model_locked", 32'(m_locked), 32'd1);
    chk("A_lost", 32'(lost), 32'd0);

    // faster input drops lock on the first short period
    repeat (2) pulse(10);
    chk("B_period", 32'(period), 32'd10);
    chk("B_locked", 32'(locked), 32'd0);

    // back to nominal: relock after 4 good periods
    repeat (4) pulse(20);
    chk("C_not_locked", 32'(locked), 32'd0);
    pulse(20);
    chk("C_locked", 32'(locked), 32'd1);

    // 21/19 alternation stays within tolerance
    repeat (4) begin pulse(21); pulse(19); end
    chk("D_locked", 32'(locked), 32'd1);
    chk("D_period", 32'(period), 32'd21);
    pulse(22); pulse(20);
    chk("D_period22", 32'(period), 32'd22);
    chk("D_unlocked", 32'(locked), 32'd0);
    repeat (3) pulse(20);
    chk("D_not_yet", 32'(locked), 32'd0);
    pulse(20);
    chk("D_relocked", 32'(locked), 32'd1);

    // input stops: timeout
    hold(1'b0, 300);
    chk("E_lost", 32'(lost), 32'd1);
    chk("E_locked", 32'(locked), 32'd0);
    chk("E_model_lost", 32'(m_lost), 32'd1);
    n0 = dut_pv_cnt;
    pulse(20);
    chk("E_lost_clear", 32'(lost), 32'd0);
    chk("E_no_pv", 32'(dut_pv_cnt - n0), 32'd0);

    // counter boundary: 255 is reported, 256 times out
    pulse(255); pulse(40);
    chk("F_period255", 32'(period), 32'd255);
    chk("F_lost255", 32'(lost), 32'd0);
    pulse(256);
    n0 = dut_pv_cnt;
    pulse(20);
    chk("F_no_pv", 32'(dut_pv_cnt - n0), 32'd0);
    chk("F_period_kept", 32'(period), 32'd40);

    // reset mid-period while locked
    repeat (5) pulse(20);
    chk("G_locked", 32'(locked), 32'd1);
    hold(1'b1, 7);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    chk("G_period0", 32'(period), 32'd0);
    chk("G_pv0", 32'(period_valid), 32'd0);
    chk("G_locked0", 32'(locked), 32'd0);
    chk("G_lost0", 32'(lost), 32'd0);
    hold(1'b0, 11);
    repeat (4) pulse(20);
    chk("G_four_rises", 32'(locked), 32'd0);
    pulse(20);
    chk("G_five_rises", 32'(locked), 32'd1);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) begin
        p = EXP - 3 + int'($urandom_range(0, 6));
        pulse(p);
      end else if (sel == 6) begin
        p = int'($urandom_range(2, 40));
        pulse(p);
      end else if (sel == 7) begin
        p = int'($urandom_range(240, 270));
        pulse(p);
      end else if (sel == 8) begin
        p = int'($urandom_range(1, 3));
        for (int k = 0; k < p; k++) tick(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        for (int k = 0; k < 10; k++) tick(1'($urandom_range(0, 1)), 1'b1);
      end
    end
    hold(1'b0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
